// File: rtl/gray_code_counter_src.sv
// gray_code_counter_src
//   Registered up/down Gray-code counter with a valid/ready output handshake.
//   The count is held in binary and the Gray code is registered. When the
//   consumer applies back-pressure, counting stalls so that no code is skipped.
//
// Parameters
//   WIDTH          counter / code width in bits (>= 2)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_en           count enable
//   i_up_dn        1 = count up, 0 = count down
//   i_load         synchronous load strobe; overrides i_en
//   i_load_bin     binary value to load
//   i_gray_ready   consumer accepts o_gray_out this cycle
//   o_gray_out     registered Gray code of the current count
//   o_gray_valid   o_gray_out holds a code not yet accepted
//   o_tc           registered terminal count: all-ones (up) / zero (down)
//   o_wrap         one-cycle pulse: count wrapped on the last edge
//
// Configuration macro
//   GRAY_CNT_SAT_EN  when defined, the counter saturates at all-ones (up) or
//                    zero (down) instead of wrapping.

module gray_code_counter_src #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_bin,
  input  logic             i_gray_ready,
  output logic [WIDTH-1:0] o_gray_out,
  output logic             o_gray_valid,
  output logic             o_tc,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] MaxVal = '1;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_valid;
  logic             r_tc;
  logic             r_wrap;

  logic             w_free;
  logic             w_at_end;
  logic             w_step;
  logic             w_adv;
  logic [WIDTH-1:0] w_bin_d;
  logic [WIDTH-1:0] w_gray_d;
  logic             w_valid_d;
  logic             w_tc_d;
  logic             w_wrap_d;

  always_comb begin
    w_free   = ~r_valid | i_gray_ready;
    // Count sits at the end of its range in the current direction.
    w_at_end = i_up_dn ? (r_bin == MaxVal) : (r_bin == '0);
    w_step   = i_en & ~i_load & w_free;
`ifdef GRAY_CNT_SAT_EN
    // A step at the range end is swallowed: nothing new to present.
    w_adv    = w_step & ~w_at_end;
`else
    w_adv    = w_step;
`endif

    w_bin_d   = r_bin;
    w_valid_d = r_valid & ~i_gray_ready;
    w_wrap_d  = 1'b0;

    if (i_load) begin
      w_bin_d   = i_load_bin;
      w_valid_d = 1'b1;
    end else if (w_adv) begin
      w_bin_d   = i_up_dn ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
      w_valid_d = 1'b1;
      w_wrap_d  = w_at_end;
    end

    // tc tracks the direction sampled on this edge, even without a step.
    w_tc_d   = i_up_dn ? (w_bin_d == MaxVal) : (w_bin_d == '0);
    w_gray_d = w_bin_d ^ (w_bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_valid <= 1'b0;
      r_tc    <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_bin   <= w_bin_d;
      r_gray  <= w_gray_d;
      r_valid <= w_valid_d;
      r_tc    <= w_tc_d;
      r_wrap  <= w_wrap_d;
    end
  end

  assign o_gray_out   = r_gray;
  assign o_gray_valid = r_valid;
  assign o_tc         = r_tc;
  assign o_wrap       = r_wrap;

endmodule

// File: tb/tb_gray_code_counter_src.sv
// Self-checking bench for gray_code_counter_src (WIDTH = 4).

module tb_gray_code_counter_src;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_bin;
  logic       gray_ready;
  logic [3:0] gray_out;
  logic       gray_valid;
  logic       tc;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] gray;
    logic       valid;
    logic       tc;
    logic       wrap;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_bin;
  logic       m_valid;

  gray_code_counter_src #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (en),
    .i_up_dn      (up_dn),
    .i_load       (load),
    .i_load_bin   (load_bin),
    .i_gray_ready (gray_ready),
    .o_gray_out   (gray_out),
    .o_gray_valid (gray_valid),
    .o_tc         (tc),
    .o_wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Predict the next state from the current inputs, push it, clock, then pop and compare.
  task automatic tick(input string tag);
    exp_t       e;
    exp_t       p;
    logic [3:0] nb;
    logic       nv;
    logic       nw;
    nb = m_bin;
    nv = m_valid && !gray_ready;
    nw = 1'b0;
    if (load) begin
      nb = load_bin;
      nv = 1'b1;
    end else if (en && (!m_valid || gray_ready)) begin
      if (up_dn && m_bin == 4'hF) begin
`ifndef GRAY_CNT_SAT_EN
        nb = 4'h0;
        nv = 1'b1;
        nw = 1'b1;
`endif
      end else if (!up_dn && m_bin == 4'h0) begin
`ifndef GRAY_CNT_SAT_EN
        nb = 4'hF;
        nv = 1'b1;
        nw = 1'b1;
`endif
      end else begin
        nb = up_dn ? m_bin + 4'd1 : m_bin - 4'd1;
        nv = 1'b1;
      end
    end
    e.gray  = to_gray(nb);
    e.valid = nv;
    e.tc    = up_dn ? (nb == 4'hF) : (nb == 4'h0);
    e.wrap  = nw;
    sb_q.push_back(e);
    m_bin   = nb;
    m_valid = nv;
    @(posedge clk);
    #1;
    p = sb_q.pop_front();
    check({tag, ".gray"},  32'(gray_out),   32'(p.gray));
    check({tag, ".valid"}, 32'(gray_valid), 32'(p.valid));
    check({tag, ".tc"},    32'(tc),         32'(p.tc));
    check({tag, ".wrap"},  32'(wrap),       32'(p.wrap));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".gray"},  32'(gray_out),   32'h0);
    check({tag, ".valid"}, 32'(gray_valid), 32'h0);
    check({tag, ".tc"},    32'(tc),         32'h0);
    check({tag, ".wrap"},  32'(wrap),       32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    up_dn      = 1'b1;
    load       = 1'b0;
    load_bin   = 4'h0;
    gray_ready = 1'b1;
    m_bin      = 4'h0;
    m_valid    = 1'b0;
    #2;
    check_reset_vals("por");
    #1 rst_n = 1'b1;

`ifndef GRAY_CNT_SAT_EN
    // Up-count through a full wrap.
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick("up");
      if (i == 1) check("up.first", 32'(gray_out), 32'h1);
      if (i == 3) check("up.third", 32'(gray_out), 32'h2);
      if (i == 15) begin
        check("up.g1000", 32'(gray_out), 32'h8);
        check("up.tc", 32'(tc), 32'h1);
      end
    end
    check("up.wrapg", 32'(gray_out), 32'h0);
    check("up.wrap", 32'(wrap), 32'h1);

    // Down-count from a loaded 2 across the zero boundary.
    en = 1'b0; up_dn = 1'b0; load = 1'b1; load_bin = 4'd2;
    tick("dnld");
    check("dn.ld", 32'(gray_out), 32'h3);
    load = 1'b0; en = 1'b1;
    tick("dn1");
    check("dn.g1", 32'(gray_out), 32'h1);
    tick("dn0");
    check("dn.g0", 32'(gray_out), 32'h0);
    check("dn.tc", 32'(tc), 32'h1);
    tick("dnwrap");
    check("dn.g15", 32'(gray_out), 32'h8);
    check("dn.wrap", 32'(wrap), 32'h1);

    // Back-pressure at 0010: code held, then resumes with 0110.
    up_dn = 1'b1; load = 1'b1; load_bin = 4'd2; en = 1'b0;
    tick("bpld");
    load = 1'b0; en = 1'b1;
    tick("bpstep");
    check("bp.g0010", 32'(gray_out), 32'h2);
    gray_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick("bphold");
    check("bp.held", 32'(gray_out), 32'h2);
    check("bp.valid", 32'(gray_valid), 32'h1);
    gray_ready = 1'b1;
    tick("bprel");
    check("bp.g0110", 32'(gray_out), 32'h6);

    // Load overrides en and an unaccepted code.
    gray_ready = 1'b0; load = 1'b1; load_bin = 4'd9;
    tick("ldpri");
    check("ld.g1101", 32'(gray_out), 32'hD);
    check("ld.wrap", 32'(wrap), 32'h0);
    load = 1'b0; en = 1'b0;
    tick("stallidle");
    gray_ready = 1'b1;
    tick("drain");
    check("drain.valid", 32'(gray_valid), 32'h0);

    // tc follows up_dn without a step.
    load = 1'b1; load_bin = 4'd0;
    tick("ld0");
    load = 1'b0; up_dn = 1'b0;
    tick("tcdir");
    check("tcdir.tc", 32'(tc), 32'h1);

    // Mid-count async reset at 0110.
    up_dn = 1'b1; load = 1'b1; load_bin = 4'd4;
    tick("ld4");
    load = 1'b0; en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    m_bin = 4'h0; m_valid = 1'b0; sb_q.delete();
    #1 rst_n = 1'b1;
    tick("postrst");
    check("postrst.g", 32'(gray_out), 32'h1);
`else
    // Saturating build: 20 up edges stop at 1000 with no wrap.
    en = 1'b1;
    for (int i = 0; i < 20; i++) tick("sat");
    check("sat.g1000", 32'(gray_out), 32'h8);
    check("sat.tc", 32'(tc), 32'h1);
    check("sat.valid", 32'(gray_valid), 32'h0);
    up_dn = 1'b0;
    for (int i = 0; i < 17; i++) tick("satdn");
    check("satdn.g0", 32'(gray_out), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
